phase_scheduler: RTL and testbench
==================================

# phase_scheduler

Upstream stage of `intersection`: latches traffic requests for the four phases (pedestrian, up, down, turn), runs the green/yellow/all-red timing state machine, and produces the `priority_*` permutation that `intersection` consumes. Priorities rotate least-recently-served, so `priority_*` is a permutation of 0..3 in every cycle with reset deasserted.

## Interface
- `MIN_GREEN`, 8: minimum green cycles when another phase is waiting.
- `MAX_GREEN`, 32: green cycles when no other phase is waiting.
- `YELLOW_TIME`, 3: yellow cycles.
- `ALL_RED_TIME`, 2: all-red cycles after yellow.
- `CNT_W`, 6: phase timer width. Required: 1 ≤ `MIN_GREEN` ≤ `MAX_GREEN` < 2^`CNT_W`; `YELLOW_TIME`, `ALL_RED_TIME` ≥ 1 and < 2^`CNT_W`.

Ports:
- `clock` in 1: clock.
- `reset` in 1: reset, synchronous, active-low.
- `req_pedestrian`, `req_up`, `req_down`, `req_turn` in 1 each: request pulses, sampled every edge.
- `priority_pedestrian`, `priority_up`, `priority_down`, `priority_turn` out 2 each: 0 = highest priority.
- `green` out 4: one-hot; bit0 ped, bit1 up, bit2 down, bit3 turn.
- `yellow` out 4: one-hot, same bit order.
- `phase_done` out 1: one-cycle pulse on the last all-red cycle.

## Operation
- **Reset (`reset`=0 at an edge):** state IDLE, timer 0, `pending`=0, `green`=0, `yellow`=0, `phase_done`=0. Priorities are ped 0, up 1, down 2, turn 3. A reset mid-phase aborts to IDLE with the same values.
- **Pending:** `pending[i]` sets on `req_i`. It clears on the edge that grants phase i (entry to GREEN). A request for the phase currently GREEN or YELLOW is dropped. A request for the phase being granted on the same edge is also dropped (clear wins).
- **Selection:** among set `pending` bits, pick the phase with the smallest priority value. Ties are impossible.
- **FSM states:** IDLE, GREEN, YELLOW, ALL_RED. The current phase is held in a 2-bit register.
  - IDLE → GREEN: when `pending`≠0. Timer cleared.
  - GREEN → YELLOW: when (timer ≥ `MIN_GREEN`−1 and `pending` has a bit other than the current phase) or timer = `MAX_GREEN`−1.
  - YELLOW → ALL_RED: when timer = `YELLOW_TIME`−1.
  - ALL_RED → GREEN: when timer = `ALL_RED_TIME`−1 and `pending`≠0, selecting again on that edge.
  - ALL_RED → IDLE: when timer = `ALL_RED_TIME`−1 and `pending`=0.
  - The timer resets to 0 on every state change and otherwise increments. It never wraps.
- **Priority rotation:** on the GREEN→YELLOW edge, let p be the served phase's old priority. The served phase becomes 3. Every phase with priority > p decrements by 1. All others are unchanged, so the permutation is preserved.
- **Outputs:** `green`/`yellow` are decoded from registered state and phase, so they are glitch-free. In IDLE and ALL_RED all bits are 0.

## Timing
- A request pulse in cycle n is pending from n+1. From IDLE, `green` is high from n+2.
- GREEN lasts exactly `MIN_GREEN` cycles if another request is pending by then. If one arrives later, GREEN ends the cycle after it becomes pending. Otherwise GREEN lasts `MAX_GREEN` cycles.
- YELLOW lasts exactly `YELLOW_TIME` cycles and ALL_RED exactly `ALL_RED_TIME` cycles. `phase_done` is high in the final ALL_RED cycle.
- Updated priorities are visible from the first YELLOW cycle.
- ALL_RED → GREEN has zero idle cycles between phases.

## Structure
- `intersection_pkg` holds:
  - `phase_t` (PED=0, UP=1, DOWN=2, TURN=3);
  - `prio_t` (logic [1:0]);
  - `sched_state_t` (IDLE, GREEN, YELLOW, ALL_RED);
  - reset priority constants.
- One sub-module, `priority_rotator`: combinational next-permutation computed from the current priorities and the served phase. It is shared with the formal checker.
- The existing priority checker binds to this block unchanged via port-name match.

## Test plan
- **Reset values:** hold `reset`=0 for 2 cycles → priorities 0/1/2/3, `green`=`yellow`=0, `phase_done`=0.
- **Single request:** `req_up` pulse in cycle 0 from IDLE → `green`=0010 in cycles 2–33, `yellow`=0010 in 34–36, all-red 37–38, `phase_done` in 38, then IDLE. Priorities from cycle 34: ped 0, up 3, down 1, turn 2.
- **All four at once:** all requests pulsed in cycle 0 → service order ped, up, down, turn. The first three greens last 8 cycles each and turn lasts 32. Final priorities are 0/1/2/3.
- **Own-phase request dropped:** `req_up` during up's GREEN → dropped, no second up service, GREEN ends at `MAX_GREEN`.
- **Competitor after minimum green:** `req_turn` pulsed in cycle 20 of an up green that started at cycle 2 → yellow starts in cycle 22.
- **Reset mid-phase:** `reset`=0 during YELLOW → next cycle IDLE, all lights off, `pending`=0, priorities 0/1/2/3. A formal run of the bound checker proves the permutation property holds.

Source files
------------

// File: rtl/intersection_pkg.sv
// Shared types and reset constants for the intersection controller slice.
package intersection_pkg;

  typedef enum logic [1:0] {
    PED  = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2,
    TURN = 2'd3
  } phase_t;

  typedef logic [1:0] prio_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GREEN   = 2'd1,
    YELLOW  = 2'd2,
    ALL_RED = 2'd3
  } sched_state_t;

  localparam prio_t RST_PRIO_PED  = 2'd0;
  localparam prio_t RST_PRIO_UP   = 2'd1;
  localparam prio_t RST_PRIO_DOWN = 2'd2;
  localparam prio_t RST_PRIO_TURN = 2'd3;

endpackage

// File: rtl/priority_rotator.sv
// Least-recently-served rotation: served phase drops to 3, phases ranked below it move up one.
module priority_rotator
  import intersection_pkg::*;
(
  input  prio_t [3:0] prio_cur,
  input  phase_t      served,
  output prio_t [3:0] prio_next
);

  prio_t p_served;

  always_comb begin
    prio_next = prio_cur;
    p_served  = prio_cur[served];
    for (int i = 0; i < 4; i++) begin
      if (i == int'(served))
        prio_next[i] = 2'd3;
      else if (prio_cur[i] > p_served)
        prio_next[i] = prio_cur[i] - 2'd1;
    end
  end

endmodule

// File: rtl/phase_scheduler.sv
// Request latching, green/yellow/all-red sequencing and LRS priority generation for four phases.
//   state   | meaning
//   IDLE    | no phase served, waiting for any pending request
//   GREEN   | current phase has right of way
//   YELLOW  | current phase clearing
//   ALL_RED | inter-phase clearance; phase_done on its last cycle
module phase_scheduler
  import intersection_pkg::*;
#(
  parameter int MIN_GREEN    = 8,
  parameter int MAX_GREEN    = 32,
  parameter int YELLOW_TIME  = 3,
  parameter int ALL_RED_TIME = 2,
  parameter int CNT_W        = 6
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_pedestrian,
  input  logic       req_up,
  input  logic       req_down,
  input  logic       req_turn,
  output logic [1:0] priority_pedestrian,
  output logic [1:0] priority_up,
  output logic [1:0] priority_down,
  output logic [1:0] priority_turn,
  output logic [3:0] green,
  output logic [3:0] yellow,
  output logic       phase_done
);

  localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(ALL_RED_TIME - 1);

  sched_state_t     state, state_nxt;
  phase_t           phase, sel;
  logic [CNT_W-1:0] timer;
  logic [3:0]       pending, pending_nxt, req_v, phase_mask;
  prio_t [3:0]      prio, prio_rot;
  logic             grant, rotate, other_pending, found;

  assign req_v         = {req_turn, req_down, req_up, req_pedestrian};
  assign phase_mask    = 4'b0001 << phase;
  assign other_pending = |(pending & ~phase_mask);

  // Lowest priority value among pending phases wins; values are a permutation so no ties.
  always_comb begin
    sel   = PED;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (pending[i] && (!found || prio[i] < prio[sel])) begin
        sel   = phase_t'(i);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    rotate    = 1'b0;
    case (state)
      IDLE: begin
        if (|pending) begin
          state_nxt = GREEN;
          grant     = 1'b1;
        end
      end
      GREEN: begin
        if ((timer >= MIN_LAST && other_pending) || timer == MAX_LAST) begin
          state_nxt = YELLOW;
          rotate    = 1'b1;
        end
      end
      YELLOW: begin
        if (timer == YEL_LAST) state_nxt = ALL_RED;
      end
      ALL_RED: begin
        if (timer == AR_LAST) begin
          if (|pending) begin
            state_nxt = GREEN;
            grant     = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Requests for the phase holding the road are dropped; a grant clears its own bit last.
  always_comb begin
    if (state == GREEN || state == YELLOW)
      pending_nxt = pending | (req_v & ~phase_mask);
    else
      pending_nxt = pending | req_v;
    if (grant) pending_nxt[sel] = 1'b0;
  end

  priority_rotator u_rotator (
    .prio_cur  (prio),
    .served    (phase),
    .prio_next (prio_rot)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= IDLE;
      phase   <= PED;
      timer   <= '0;
      pending <= '0;
      prio    <= {RST_PRIO_TURN, RST_PRIO_DOWN, RST_PRIO_UP, RST_PRIO_PED};
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      if (grant) phase <= sel;
      if (state_nxt != state)
        timer <= '0;
      else if (timer != '1)
        timer <= timer + 1'b1;
      if (rotate) prio <= prio_rot;
    end
  end

  assign green      = (state == GREEN)  ? phase_mask : 4'b0000;
  assign yellow     = (state == YELLOW) ? phase_mask : 4'b0000;
  assign phase_done = (state == ALL_RED) && (timer == AR_LAST);

  assign priority_pedestrian = prio[PED];
  assign priority_up         = prio[UP];
  assign priority_down       = prio[DOWN];
  assign priority_turn       = prio[TURN];

endmodule

// File: tb/tb_phase_scheduler.sv
// Directed bench for phase_scheduler with hand-computed light windows and priorities.
module tb_phase_scheduler;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       req_pedestrian = 1'b0, req_up = 1'b0, req_down = 1'b0, req_turn = 1'b0;
  logic [1:0] priority_pedestrian, priority_up, priority_down, priority_turn;
  logic [3:0] green, yellow;
  logic       phase_done;

  int n_tests = 0;
  int n_fail  = 0;

  phase_scheduler dut (
    .clock               (clock),
    .reset               (reset),
    .req_pedestrian      (req_pedestrian),
    .req_up              (req_up),
    .req_down            (req_down),
    .req_turn            (req_turn),
    .priority_pedestrian (priority_pedestrian),
    .priority_up         (priority_up),
    .priority_down       (priority_down),
    .priority_turn       (priority_turn),
    .green               (green),
    .yellow              (yellow),
    .phase_done          (phase_done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] g, input logic [3:0] y, input logic pd);
    chk({tag, " green"},      32'(green),      32'(g));
    chk({tag, " yellow"},     32'(yellow),     32'(y));
    chk({tag, " phase_done"}, 32'(phase_done), 32'(pd));
  endtask

  task automatic check_prio(input string tag, input int p0, input int p1, input int p2, input int p3);
    chk({tag, " prio_ped"},  32'(priority_pedestrian), 32'(p0));
    chk({tag, " prio_up"},   32'(priority_up),         32'(p1));
    chk({tag, " prio_down"}, 32'(priority_down),       32'(p2));
    chk({tag, " prio_turn"}, 32'(priority_turn),       32'(p3));
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  // Single up service: green 2..33, yellow 34..36, all-red 37..38, done at 38.
  task automatic single_up(input string tag, input bit repeat_req);
    logic [3:0] eg, ey;
    for (int c = 0; c <= 45; c++) begin
      req_up = (c == 0) || (repeat_req && c == 10);
      eg = (c >= 2  && c <= 33) ? 4'b0010 : 4'b0000;
      ey = (c >= 34 && c <= 36) ? 4'b0010 : 4'b0000;
      check_out($sformatf("%s c%0d", tag, c), eg, ey, c == 38);
      if (c == 34) check_prio({tag, " rot"}, 0, 3, 1, 2);
      step();
    end
    req_up = 1'b0;
  endtask

  initial begin
    int glen;

    reset = 1'b0;
    step();
    step();
    check_out("reset", 4'b0000, 4'b0000, 1'b0);
    check_prio("reset", 0, 1, 2, 3);
    reset = 1'b1;

    single_up("single", 1'b0);

    // All four at once: ped, up, down (8 each), then turn alone (32).
    do_reset();
    {req_pedestrian, req_up, req_down, req_turn} = 4'b1111;
    check_out("all c0", 4'b0000, 4'b0000, 1'b0);
    step();
    {req_pedestrian, req_up, req_down, req_turn} = 4'b0000;
    check_out("all c1", 4'b0000, 4'b0000, 1'b0);
    step();
    for (int k = 0; k < 4; k++) begin
      glen = (k < 3) ? 8 : 32;
      for (int g = 0; g < glen; g++) begin
        check_out($sformatf("all p%0d g%0d", k, g), 4'(1 << k), 4'b0000, 1'b0);
        step();
      end
      for (int y = 0; y < 3; y++) begin
        check_out($sformatf("all p%0d y%0d", k, y), 4'b0000, 4'(1 << k), 1'b0);
        step();
      end
      for (int a = 0; a < 2; a++) begin
        check_out($sformatf("all p%0d r%0d", k, a), 4'b0000, 4'b0000, a == 1);
        step();
      end
    end
    check_out("all idle", 4'b0000, 4'b0000, 1'b0);
    check_prio("all final", 0, 1, 2, 3);

    // Second up request during its own green must be ignored.
    single_up("own", 1'b1);

    // Turn arrives at cycle 20 of up green; then reset mid-yellow.
    do_reset();
    for (int c = 0; c <= 23; c++) begin
      req_up   = (c == 0);
      req_turn = (c == 20);
      if (c == 21) check_out("comp c21", 4'b0010, 4'b0000, 1'b0);
      if (c == 22) check_out("comp c22", 4'b0000, 4'b0010, 1'b0);
      if (c == 23) begin
        check_out("comp c23", 4'b0000, 4'b0010, 1'b0);
        check_prio("comp rot", 0, 3, 1, 2);
        reset = 1'b0;
      end
      step();
    end
    {req_up, req_turn} = 2'b00;
    check_out("midrst", 4'b0000, 4'b0000, 1'b0);
    check_prio("midrst", 0, 1, 2, 3);
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      check_out($sformatf("midrst idle%0d", c), 4'b0000, 4'b0000, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
